// File: rtl/logic_gate_pkg.sv
// Shared types for the logic gate arbiter: opcodes, FSM states
// and the opcode legality helper.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOT   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XOR   = 3'd5,
    OP_RSVD6 = 3'd6,
    OP_RSVD7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input op_e op);
    return (op != OP_RSVD6) && (op != OP_RSVD7);
  endfunction

endpackage

// File: rtl/logic_gate_rr_pick.sv
// Combinational round-robin picker: first valid requester
// searching from last_grant+1, wrapping at NUM_REQ.
module logic_gate_rr_pick
  import logic_gate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant,
  output logic               any_valid
);

  int idx;

  // Scan farthest-first so the nearest valid requester wins last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        grant     = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_gate_arbiter.sv
// Round-robin shared bitwise logic unit with IDLE/EXEC/RESP sequencer.
// Optional resp_err port enabled by LOGIC_ARB_ERR_EN.
module logic_gate_arbiter
  import logic_gate_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
`ifdef LOGIC_ARB_ERR_EN
  output logic                     resp_err,
`endif
  output logic [ID_W-1:0]          resp_id
);

  state_e            state;
  state_e            state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant;
  logic              any_valid;
  logic              acc;
  logic [ID_W-1:0]   id_q;
  op_e               op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;

  logic_gate_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  assign acc = (state == ST_IDLE) && any_valid;

  // Gated by rst_n so req_ready reads zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && acc) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (any_valid)  state_nxt = ST_EXEC;
      ST_EXEC:                 state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
`ifdef LOGIC_ARB_ERR_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_valid) begin
            id_q <= grant;
            op_q <= op_e'(req_op[3*int'(grant) +: 3]);
            a_q  <= req_a[WIDTH*int'(grant) +: WIDTH];
            b_q  <= req_b[WIDTH*int'(grant) +: WIDTH];
          end
        end
        ST_EXEC: begin
          resp_valid <= 1'b1;
          resp_id    <= id_q;
          last_grant <= id_q;
          case (op_q)
            OP_AND:  resp_data <= a_q & b_q;
            OP_OR:   resp_data <= a_q | b_q;
            OP_NOT:  resp_data <= ~a_q;
            OP_NAND: resp_data <= ~(a_q & b_q);
            OP_NOR:  resp_data <= ~(a_q | b_q);
            OP_XOR:  resp_data <= a_q ^ b_q;
            default: resp_data <= '0;
          endcase
`ifdef LOGIC_ARB_ERR_EN
          resp_err <= !op_legal(op_q);
`endif
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
`ifdef LOGIC_ARB_ERR_EN
            resp_err   <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// Self-checking bench for logic_gate_arbiter (NUM_REQ=4, WIDTH=8):
// vector table, random ops vs model, fairness, stall and reset cases.
module tb_logic_gate_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op = '0;
  logic [WIDTH*NUM_REQ-1:0] req_a = '0;
  logic [WIDTH*NUM_REQ-1:0] req_b = '0;
  logic                     resp_valid;
  logic                     resp_ready = 1'b0;
  logic [WIDTH-1:0]         resp_data;
  logic [ID_W-1:0]          resp_id;
`ifdef LOGIC_ARB_ERR_EN
  logic                     resp_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_gate_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
`ifdef LOGIC_ARB_ERR_EN
    .resp_err   (resp_err),
`endif
    .resp_id    (resp_id)
  );

  typedef struct {
    int         id;
    int         op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=event", name);
  endtask

  function automatic logic [7:0] ref_gate(input int op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic set_req(input int id, input int op, input logic [7:0] a,
                         input logic [7:0] b);
    req_op[3*id +: 3]         = 3'(op);
    req_a[WIDTH*id +: WIDTH]  = a;
    req_b[WIDTH*id +: WIDTH]  = b;
  endtask

  task automatic run_txn(input int id, input int op, input logic [7:0] a,
                         input logic [7:0] b, output logic [7:0] d,
                         output int rid, output int err, output int lat);
    int n;
    d = '0; rid = -1; err = -1; lat = 0;
    @(negedge clk);
    set_req(id, op, a, b);
    req_valid[id] = 1'b1;
    resp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready[id]) begin
      timeout("txn_grant");
      req_valid[id] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (!resp_valid) begin
      timeout("txn_resp");
      return;
    end
    d   = resp_data;
    rid = int'(resp_id);
`ifdef LOGIC_ARB_ERR_EN
    err = int'(resp_err);
`else
    err = 0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, d0;
    logic [1:0] i0;
    int rid, err, lat, n, got, prev_acc, id, op;
    logic [7:0] a, b;

    tbl[0] = '{2, 0, 8'hF0, 8'h3C, 8'h30};
    tbl[1] = '{0, 0, 8'hAA, 8'hCC, 8'h88};
    tbl[2] = '{0, 1, 8'hAA, 8'hCC, 8'hEE};
    tbl[3] = '{0, 2, 8'hAA, 8'hCC, 8'h55};
    tbl[4] = '{0, 3, 8'hAA, 8'hCC, 8'h77};
    tbl[5] = '{0, 4, 8'hAA, 8'hCC, 8'h11};
    tbl[6] = '{0, 5, 8'hAA, 8'hCC, 8'h66};
    tbl[7] = '{3, 7, 8'hFF, 8'hFF, 8'h00};
    tbl[8] = '{1, 6, 8'h5A, 8'hA5, 8'h00};

    // reset values
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_data", 32'(resp_data), 0);
    check("rst_id", 32'(resp_id), 0);
`ifdef LOGIC_ARB_ERR_EN
    check("rst_err", 32'(resp_err), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    foreach (tbl[k]) begin
      run_txn(tbl[k].id, tbl[k].op, tbl[k].a, tbl[k].b, d, rid, err, lat);
      check($sformatf("vec%0d_data", k), 32'(d), 32'(tbl[k].exp));
      check($sformatf("vec%0d_id", k), 32'(rid), 32'(tbl[k].id));
      check($sformatf("vec%0d_lat", k), 32'(lat), 2);
`ifdef LOGIC_ARB_ERR_EN
      check($sformatf("vec%0d_err", k), 32'(err), 32'(tbl[k].op >= 6));
`endif
      @(negedge clk);
      check($sformatf("vec%0d_drop", k), 32'(resp_valid), 0);
    end

    // random single-requester ops
    for (int k = 0; k < 40; k++) begin
      id = int'($urandom_range(0, NUM_REQ - 1));
      op = int'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      run_txn(id, op, a, b, d, rid, err, lat);
      check($sformatf("rnd%0d_data", k), 32'(d), 32'(ref_gate(op, a, b)));
      check($sformatf("rnd%0d_id", k), 32'(rid), 32'(id));
`ifdef LOGIC_ARB_ERR_EN
      check($sformatf("rnd%0d_err", k), 32'(err), 32'(op >= 6));
`endif
    end

    // backpressure with a competing requester waiting
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(1, 5, 8'h5A, 8'h0F);
    set_req(3, 1, 8'h81, 8'h42);
    req_valid[1] = 1'b1;
    #1;
    check("bp_grant1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    req_valid[3] = 1'b1;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(negedge clk); n++;
    end
    if (!resp_valid) timeout("bp_resp");
    d0 = resp_data;
    i0 = resp_id;
    check("bp_data", 32'(d0), 32'h55);
    check("bp_id", 32'(i0), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 1);
      check("bp_hold_data", 32'(resp_data), 32'(d0));
      check("bp_hold_id", 32'(resp_id), 32'(i0));
      check("bp_hold_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", 32'(resp_valid), 0);
    check("bp_release_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid[3] = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(negedge clk); n++;
    end
    check("bp_next_id", 32'(resp_id), 3);
    check("bp_next_data", 32'(resp_data), 32'hC3);

    // reset during EXEC: last_grant=1 beforehand, so without reset
    // requesters {0,2} would go to 2
    run_txn(1, 0, 8'h0F, 8'hFF, d, rid, err, lat);
    check("pre_rst_id", 32'(rid), 1);
    @(negedge clk);
    set_req(2, 5, 8'h12, 8'h34);
    req_valid[2] = 1'b1;
    #1;
    check("mid_grant2", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_data", 32'(resp_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    check("mid_no_resp", 32'(n), 0);
    set_req(0, 0, 8'hF0, 8'h3C);
    set_req(2, 1, 8'h01, 8'h02);
    req_valid = 4'b0101;
    #1;
    check("mid_next_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(negedge clk); n++;
    end
    check("mid_next_id", 32'(resp_id), 0);
    check("mid_next_data", 32'(resp_data), 32'h30);

    // fairness: all requesters valid from reset
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      set_req(k, 0, 8'(8'h11 * (k + 1)), 8'h0F);
    req_valid = '1;
    #1;
    check("fair_rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    prev_acc = 0;
    n = 0;
    while (got < 6 && n < 60) begin
      #1;
      check("fair_onehot", 32'($countones(req_ready) <= 1), 1);
      if (prev_acc != 0) check("fair_exec_ready", 32'(req_ready), 0);
      if (resp_valid) begin
        check("fair_resp_ready", 32'(req_ready), 0);
        check($sformatf("fair_id%0d", got), 32'(resp_id), 32'(got % NUM_REQ));
        check($sformatf("fair_data%0d", got), 32'(resp_data),
              32'(ref_gate(0, 8'(8'h11 * (got % NUM_REQ + 1)), 8'h0F)));
        got++;
      end
      prev_acc = (req_ready != 0) ? 1 : 0;
      @(negedge clk);
      n++;
    end
    if (got < 6) timeout("fair_count");
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_gate_arbiter.md
# logic_gate_arbiter

Shares one registered bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR on WIDTH-bit operands) among NUM_REQ requesters. Each requester presents an opcode and two operands through a valid/ready handshake. A round-robin arbiter grants one requester at a time, and a three-state sequencer executes the operation and returns the result, tagged with the requester index, over a valid/ready response channel. The block sits between client logic and the gate datapath, and is the only path to it.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- ID_W, $clog2(NUM_REQ), derived localparam, width of resp_id
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- req_op  input  3*NUM_REQ  packed opcodes; requester i uses bits [3i+2:3i]
- req_a  input  WIDTH*NUM_REQ  packed operand a
- req_b  input  WIDTH*NUM_REQ  packed operand b (ignored for NOT)
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_data  output  WIDTH  result
- resp_id  output  ID_W  index of the requester served
- resp_err  output  1  illegal opcode flag; present only with LOGIC_ARB_ERR_EN

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR; 6 and 7 are illegal.
- Illegal opcodes give resp_data = 0.
- States:
  - IDLE: waiting for a request.
  - EXEC: computing the result.
  - RESP: holding the result until the consumer takes it.
- IDLE:
  - Grant = first requester with req_valid high, searching from last_grant+1 modulo NUM_REQ.
  - req_ready[grant] is high combinationally in IDLE only.
  - On the handshake: latch op, a, b and id, then go to EXEC.
- EXEC:
  - Compute the result and register it into resp_data.
  - Set resp_valid and go to RESP.
  - Update last_grant to id.
- RESP:
  - Hold resp_valid, resp_data, resp_id and resp_err stable until resp_ready is high.
  - On the handshake: clear resp_valid and return to IDLE.
- Requests are never accepted outside IDLE; req_ready is all-zero in EXEC and RESP.
- Requesters hold req_valid and their operands until accepted. The block does not require a requester to keep req_valid high while it is not granted.
- The grant depends combinationally on req_valid. req_ready never depends on resp_ready.

## Timing
- Reset values: state IDLE, last_grant = NUM_REQ-1 (requester 0 has first priority), req_ready = 0, resp_valid = 0, resp_data = 0, resp_id = 0, resp_err = 0.
- Latency: request accepted at edge N → resp_valid high after edge N+1.
- Throughput: one transaction per 3 cycles minimum when resp_ready is held high.
- A response handshake at edge M allows the next request accept at edge M+1; there is no back-to-back overlap.
- Simultaneous requests are served in rotating order. No requester waits more than NUM_REQ-1 other transactions.
- Wrap-around: the search order after requester NUM_REQ-1 restarts at 0.
- If resp_ready is low indefinitely, the block stalls in RESP and the outputs do not change.
- Reset asserted mid-transaction: the transaction is dropped, no response is issued, and all outputs go to reset values immediately (asynchronous).
- Releasing reset is synchronous to clk in the surrounding design; the first grant can occur on the first edge after release.

## Configuration
- LOGIC_ARB_ERR_EN defined:
  - resp_err port exists.
  - It is set in EXEC when the latched opcode is 6 or 7, and cleared when leaving RESP.
  - resp_data = 0 for these opcodes.
- LOGIC_ARB_ERR_EN undefined:
  - No resp_err port.
  - Illegal opcodes still complete normally with resp_data = 0.

## Structure
- Shared package logic_gate_pkg holds:
  - the 3-bit opcode enum (OP_AND..OP_XOR, plus OP_RSVD6/7)
  - the state enum (ST_IDLE, ST_EXEC, ST_RESP)
  - a function op_legal().
- Sub-module logic_gate_rr_pick: combinational round-robin picker.
  - Inputs: req_valid, last_grant.
  - Outputs: grant index, any_valid.
- The gate evaluation itself stays inline in the EXEC register logic.

## Test plan
All scenarios use NUM_REQ = 4, WIDTH = 8.
- Single request: requester 2 issues op 0, a = 0xF0, b = 0x3C. Expected: resp_data = 0x30, resp_id = 2, and resp_valid rises 2 edges after req_valid.
- Opcode sweep: requester 0 runs ops 0–5 with a = 0xAA, b = 0xCC. Expected results in order: 0x88, 0xEE, 0x55, 0x77, 0x11, 0x66.
- Fairness: all four requesters valid continuously from reset. Expected resp_id sequence: 0, 1, 2, 3, 0, 1. No req_ready is ever high when the state is not IDLE.
- Backpressure: resp_ready held low for 5 cycles. Expected: resp_valid, resp_data and resp_id stay stable, req_ready stays 0, and IDLE is re-entered one edge after resp_ready rises.
- Reset mid-op: rst_n pulled low while in EXEC. Expected: resp_valid = 0 immediately and no response after release. The next grant goes to requester 0.
- Illegal opcode 7 with LOGIC_ARB_ERR_EN defined, a = 0xFF, b = 0xFF. Expected: resp_data = 0x00 and resp_err = 1. Without the macro: resp_data = 0x00 and the transaction completes normally.
